// File: rtl/logical_operand_gen.sv
// Operand sequencer for the logical_operators stage: emits (A, B) pairs over valid/ready
// in exhaustive, walking-one or Galois-LFSR order, one vector per accepted transfer.
module logical_operand_gen #(
    parameter int                 WIDTH      = 4,
    parameter int                 RAND_COUNT = 16,
    parameter logic [2*WIDTH-1:0] LFSR_SEED  = 8'h01,
    parameter logic [2*WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               ready,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   vec_cnt
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;

    localparam logic [VW-1:0]    SEED      = (LFSR_SEED == '0) ? VW'(1) : LFSR_SEED;
    localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);
    localparam logic [CW-1:0]    LAST_EXH  = {1'b0, {VW{1'b1}}};
    localparam logic [CW-1:0]    LAST_WALK = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    LAST_RAND = CW'(RAND_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       mode_q;
    logic             xfer;
    logic             last_vec;
    logic             launch;
    logic [VW-1:0]    cur_vec;
    logic [VW-1:0]    step_vec;
    logic [VW-1:0]    first_vec;
    logic [WIDTH-1:0] a_shift;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_comb begin
        xfer       = valid && ready;
        cur_vec    = {A, B};
        a_shift    = A << 1;
        state_next = state;
        launch     = 1'b0;

        case (mode_q)
            2'd0:    last_vec = (vec_cnt == LAST_EXH);
            2'd1:    last_vec = (vec_cnt == LAST_WALK);
            default: last_vec = (vec_cnt == LAST_RAND);
        endcase

        // Successor of the vector currently presented, in the latched mode
        case (mode_q)
            2'd0:    step_vec = cur_vec + VW'(1);
            2'd1:    step_vec = {a_shift, ~a_shift};
            default: step_vec = cur_vec[0] ? ((cur_vec >> 1) ^ LFSR_TAPS) : (cur_vec >> 1);
        endcase

        case (mode)
            2'd0:    first_vec = '0;
            2'd1:    first_vec = {ONE_HOT0, ~ONE_HOT0};
            default: first_vec = SEED;
        endcase

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mode == 2'd3) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                        launch     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (xfer && last_vec) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last accepted vector stays on A/B; only valid drops when the run ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A       <= '0;
            B       <= '0;
            valid   <= 1'b0;
            vec_cnt <= '0;
            mode_q  <= 2'd0;
        end else if (state == S_IDLE && start) begin
            mode_q  <= mode;
            vec_cnt <= '0;
            if (launch) begin
                {A, B} <= first_vec;
                valid  <= 1'b1;
            end
        end else if (state == S_RUN && xfer) begin
            vec_cnt <= vec_cnt + CW'(1);
            if (last_vec) begin
                valid <= 1'b0;
            end else begin
                {A, B} <= step_vec;
            end
        end
    end

endmodule
